prim_bus_arbiter: RTL and testbench
===================================

# prim_bus_arbiter

Two-master, one-slave arbiter for the Prim 16-bit memory bus. Master 0 is the Prim core and master 1 is a secondary master such as a DMA or debug port. The block grants the single memory port with round-robin fairness and holds each grant until the slave acknowledges. It sits between the masters and the memory or peripheral decoder, and uses the same address/data/byte-select/we/ack signalling on every side.

## Interface
Parameters:
- TO_CYCLES, default 16: timeout limit in cycles. Range 2..255. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_m0_addr, i_m1_addr  in  16  master address
- i_m0_dat, i_m1_dat  in  16  master write data
- i_m0_bs, i_m1_bs  in  2  master byte select; nonzero means request
- i_m0_we, i_m1_we  in  1  master write enable
- o_m0_dat, o_m1_dat  out  16  read data returned to the master
- o_m0_ack, o_m1_ack  out  1  transfer-complete strobe to the master
- o_addr  out  16  slave address
- o_dat  out  16  slave write data
- o_bs  out  2  slave byte select
- o_we  out  1  slave write enable
- i_dat  in  16  slave read data
- i_ack  in  1  slave ack
- o_gnt  out  2  one-hot current grant; 00 in IDLE
- o_timeout  out  1  one-cycle pulse on timeout (ARB_TIMEOUT_EN only; tied 0 otherwise)

## Operation
- Request: reqN = |i_mN_bs.
- State machine with registered states IDLE, GNT0, GNT1, plus a registered last-winner bit `last`.
- IDLE:
  - Only req0 asserted -> GNT0.
  - Only req1 asserted -> GNT1.
  - Both asserted -> grant the master that is not `last`.
  - Neither asserted -> stay in IDLE.
  - On entering GNTx, set `last` <= x.
- GNTx:
  - Slave outputs (o_addr, o_dat, o_bs, o_we) are combinationally muxed from master x.
  - o_mx_ack = i_ack.
  - o_mx_dat = i_dat.
- GNTx exit conditions:
  - i_ack high -> IDLE.
  - reqx drops to 0 without ack (abort) -> IDLE. No ack is issued.
- Non-granted master: ack held 0. o_dat for that master is i_dat (don't-care).
- In IDLE the slave side is driven o_addr=0, o_dat=0, o_bs=00, o_we=0.
- While i_reset is high, o_bs=00 and o_we=0 regardless of state.
- Each completed transfer passes through IDLE. Back-to-back requests from one master therefore alternate with any pending request from the other master.

## Timing
- Reset values: state=IDLE, last=1 (master 0 wins the first tie), o_gnt=00, o_timeout=0, both acks 0, slave outputs all 0.
- Grant latency: request sampled in IDLE at edge N; grant and slave outputs valid from cycle N+1.
- With a zero-wait slave (ack in the first granted cycle), each transfer occupies 2 cycles: IDLE, then GNT.
- Ack is combinational, in the same cycle as i_ack. The master samples it at that edge.
- Simultaneous i_ack and request drop: treated as ack, and ack is issued.
- Reset asserted mid-grant: IDLE from the next edge and the transfer is lost. The slave sees o_bs=00 from the reset cycle onward.
- A master changing its addr/bs/we while granted is passed through unfiltered; holding them stable is the master's responsibility.

## Configuration
- Macro ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to GNTx and increments each granted cycle without i_ack.
  - When the counter reaches TO_CYCLES-1 with no ack, the arbiter drives o_mx_ack=1 and o_mx_dat=16'hFFFF for that cycle and pulses o_timeout.
  - The next state is IDLE.
  - A real ack in the same cycle as expiry takes precedence: normal ack, no timeout pulse.
- When undefined:
  - No counter.
  - A grant is held indefinitely until ack or abort.
  - o_timeout is constant 0.

## Test plan
- Reset, then m0 read of 0x0100 (bs=01), slave acks in the first granted cycle with 0x00AB -> o_gnt=01 one cycle after request; o_m0_ack=1 and o_m0_dat=0x00AB in that cycle; IDLE next.
- Both masters request in the same cycle after reset -> m0 granted first; after its ack, IDLE, then m1 granted; m0's re-request then waits until m1's ack.
- m1 write 0x1234 to 0x2000 (bs=11, we=1), slave inserts 3 wait cycles -> o_addr, o_dat, o_we stable for 4 cycles; a single o_m1_ack pulse; m0 ack stays 0 throughout.
- m0 granted, then m0 drops bs to 00 without ack -> IDLE next cycle, no ack pulse, pending m1 granted on the following cycle.
- i_reset asserted during GNT1 with the slave stalled -> o_bs=00 in the same cycle, o_gnt=00 after the edge, no ack issued.
- With ARB_TIMEOUT_EN and TO_CYCLES=4, slave never acks -> o_m0_ack=1 and o_m0_dat=0xFFFF in the 4th granted cycle, o_timeout pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/prim_bus_arbiter.sv
// Two-master round-robin arbiter for the Prim 16-bit memory bus; grant held until slave ack or master abort.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN (TO_CYCLES sets the limit).
module prim_bus_arbiter #(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m0_dat,
    input  logic [1:0]  i_m0_bs,
    input  logic        i_m0_we,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m1_dat,
    input  logic [1:0]  i_m1_bs,
    input  logic        i_m1_we,
    output logic [15:0] o_m0_dat,
    output logic [15:0] o_m1_dat,
    output logic        o_m0_ack,
    output logic        o_m1_ack,
    output logic [15:0] o_addr,
    output logic [15:0] o_dat,
    output logic [1:0]  o_bs,
    output logic        o_we,
    input  logic [15:0] i_dat,
    input  logic        i_ack,
    output logic [1:0]  o_gnt,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    if (TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_to_cycles
        $fatal(1, "prim_bus_arbiter: TO_CYCLES must be within 2..255");
    end

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   req0, req1;
    logic   granted;
    logic   to_hit;

    assign req0    = |i_m0_bs;
    assign req1    = |i_m1_bs;
    assign granted = (state_q == GNT0) || (state_q == GNT1);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Every grant is entered from IDLE, so holding zero there clears on entry.
    always_comb begin
        cnt_d = cnt_q;
        if (!granted) begin
            cnt_d = 8'd0;
        end else if (!i_ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign to_hit = granted && !i_ack && (cnt_q == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On a tie the master that did not win last time goes first.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (i_ack || !req0 || to_hit) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (i_ack || !req1 || to_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_gnt     = 2'b00;
        o_addr    = 16'h0000;
        o_dat     = 16'h0000;
        o_bs      = 2'b00;
        o_we      = 1'b0;
        o_m0_ack  = 1'b0;
        o_m1_ack  = 1'b0;
        o_m0_dat  = i_dat;
        o_m1_dat  = i_dat;
        o_timeout = 1'b0;
        case (state_q)
            GNT0: begin
                o_gnt     = 2'b01;
                o_addr    = i_m0_addr;
                o_dat     = i_m0_dat;
                o_bs      = i_m0_bs;
                o_we      = i_m0_we;
                o_m0_ack  = i_ack || to_hit;
                o_timeout = to_hit;
                if (to_hit) begin
                    o_m0_dat = 16'hFFFF;
                end
            end
            GNT1: begin
                o_gnt     = 2'b10;
                o_addr    = i_m1_addr;
                o_dat     = i_m1_dat;
                o_bs      = i_m1_bs;
                o_we      = i_m1_we;
                o_m1_ack  = i_ack || to_hit;
                o_timeout = to_hit;
                if (to_hit) begin
                    o_m1_dat = 16'hFFFF;
                end
            end
            default: ;
        endcase
        // Reset kills the slave strobe in the same cycle and completes nothing.
        if (i_reset) begin
            o_bs      = 2'b00;
            o_we      = 1'b0;
            o_m0_ack  = 1'b0;
            o_m1_ack  = 1'b0;
            o_timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_prim_bus_arbiter.sv
// Scoreboard bench for prim_bus_arbiter: expected acks are queued by the stimulus and checked by a monitor.
module tb_prim_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat;
    logic [1:0]  i_m0_bs, i_m1_bs;
    logic        i_m0_we, i_m1_we;
    logic [15:0] o_m0_dat, o_m1_dat;
    logic        o_m0_ack, o_m1_ack;
    logic [15:0] o_addr, o_dat;
    logic [1:0]  o_bs;
    logic        o_we;
    logic [15:0] i_dat;
    logic        i_ack;
    logic [1:0]  o_gnt;
    logic        o_timeout;

    typedef struct {
        logic        mst;
        logic [15:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 i_clk = ~i_clk;

    prim_bus_arbiter #(.TO_CYCLES(4)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_m0_addr (i_m0_addr),
        .i_m0_dat  (i_m0_dat),
        .i_m0_bs   (i_m0_bs),
        .i_m0_we   (i_m0_we),
        .i_m1_addr (i_m1_addr),
        .i_m1_dat  (i_m1_dat),
        .i_m1_bs   (i_m1_bs),
        .i_m1_we   (i_m1_we),
        .o_m0_dat  (o_m0_dat),
        .o_m1_dat  (o_m1_dat),
        .o_m0_ack  (o_m0_ack),
        .o_m1_ack  (o_m1_ack),
        .o_addr    (o_addr),
        .o_dat     (o_dat),
        .o_bs      (o_bs),
        .o_we      (o_we),
        .i_dat     (i_dat),
        .i_ack     (i_ack),
        .o_gnt     (o_gnt),
        .o_timeout (o_timeout)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge i_clk);
    endtask

    task automatic push(input logic mst, input logic [15:0] dat);
        exp_t e;
        e.mst = mst;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_m0_ack && o_m1_ack) begin
                chk("both_acks", 16'({o_m1_ack, o_m0_ack}), 16'd0);
            end else if (o_m0_ack || o_m1_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 16'({o_m1_ack, o_m0_ack}), 16'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_master", 16'(o_m1_ack), 16'(e.mst));
                    chk("ack_data", o_m1_ack ? o_m1_dat : o_m0_dat, e.dat);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        i_m0_addr = 16'h0; i_m0_dat = 16'h0; i_m0_bs = 2'b00; i_m0_we = 1'b0;
        i_m1_addr = 16'h0; i_m1_dat = 16'h0; i_m1_bs = 2'b00; i_m1_we = 1'b0;
        i_dat = 16'h0; i_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        cyc();
        cyc();
        i_reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        fork
            monitor_loop();
        join_none
        cyc();
        cyc();
        neg();
        chk("rst_gnt", 16'(o_gnt), 16'd0);
        chk("rst_bs", 16'(o_bs), 16'd0);
        chk("rst_we", 16'(o_we), 16'd0);
        chk("rst_addr", o_addr, 16'h0);
        chk("rst_dat", o_dat, 16'h0);
        chk("rst_acks", 16'({o_m1_ack, o_m0_ack}), 16'd0);
        chk("rst_timeout", 16'(o_timeout), 16'd0);
        cyc();
        i_reset = 1'b0;

        // m0 read with zero-wait slave
        i_m0_addr = 16'h0100; i_m0_bs = 2'b01;
        neg();
        chk("t1_idle_gnt", 16'(o_gnt), 16'd0);
        cyc();
        i_ack = 1'b1; i_dat = 16'h00AB; push(1'b0, 16'h00AB);
        neg();
        chk("t1_gnt", 16'(o_gnt), 16'd1);
        chk("t1_addr", o_addr, 16'h0100);
        chk("t1_bs", 16'(o_bs), 16'd1);
        cyc();
        i_m0_bs = 2'b00; i_ack = 1'b0;
        neg();
        chk("t1_back_idle", 16'(o_gnt), 16'd0);

        // simultaneous requests after reset: m0, m1, then m0
        do_reset();
        i_m0_addr = 16'h0010; i_m0_bs = 2'b11;
        i_m1_addr = 16'h0020; i_m1_bs = 2'b01;
        cyc();
        i_ack = 1'b1; i_dat = 16'h1111; push(1'b0, 16'h1111);
        neg();
        chk("t2_first_gnt", 16'(o_gnt), 16'd1);
        chk("t2_first_addr", o_addr, 16'h0010);
        cyc();
        i_ack = 1'b0;
        neg();
        chk("t2_mid_idle", 16'(o_gnt), 16'd0);
        cyc();
        i_ack = 1'b1; i_dat = 16'h2222; push(1'b1, 16'h2222);
        neg();
        chk("t2_second_gnt", 16'(o_gnt), 16'd2);
        chk("t2_second_addr", o_addr, 16'h0020);
        cyc();
        i_m1_bs = 2'b00; i_ack = 1'b0;
        cyc();
        i_ack = 1'b1; i_dat = 16'h3333; push(1'b0, 16'h3333);
        neg();
        chk("t2_third_gnt", 16'(o_gnt), 16'd1);
        cyc();
        i_m0_bs = 2'b00; i_ack = 1'b0;

        // m1 write with three wait states
        i_m1_addr = 16'h2000; i_m1_dat = 16'h1234; i_m1_bs = 2'b11; i_m1_we = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                i_ack = 1'b1; i_dat = 16'hBEEF; push(1'b1, 16'hBEEF);
            end
            neg();
            chk("t3_gnt", 16'(o_gnt), 16'd2);
            chk("t3_addr", o_addr, 16'h2000);
            chk("t3_dat", o_dat, 16'h1234);
            chk("t3_we", 16'(o_we), 16'd1);
            chk("t3_m0_ack", 16'(o_m0_ack), 16'd0);
            cyc();
        end
        i_m1_bs = 2'b00; i_m1_we = 1'b0; i_ack = 1'b0;

        // m0 aborts; pending m1 then served
        i_m0_addr = 16'h0300; i_m0_bs = 2'b01;
        cyc();
        i_m1_addr = 16'h0400; i_m1_bs = 2'b01;
        neg();
        chk("t4_gnt0", 16'(o_gnt), 16'd1);
        cyc();
        i_m0_bs = 2'b00;
        neg();
        chk("t4_abort_ack", 16'(o_m0_ack), 16'd0);
        cyc();
        neg();
        chk("t4_abort_idle", 16'(o_gnt), 16'd0);
        cyc();
        i_ack = 1'b1; i_dat = 16'h4444; push(1'b1, 16'h4444);
        neg();
        chk("t4_gnt1", 16'(o_gnt), 16'd2);
        chk("t4_addr", o_addr, 16'h0400);
        cyc();
        i_m1_bs = 2'b00; i_ack = 1'b0;

        // reset during a stalled GNT1
        i_m1_addr = 16'h0500; i_m1_bs = 2'b11; i_m1_we = 1'b1;
        cyc();
        neg();
        chk("t5_gnt1", 16'(o_gnt), 16'd2);
        chk("t5_bs", 16'(o_bs), 16'd3);
        cyc();
        i_reset = 1'b1;
        neg();
        chk("t5_rst_bs", 16'(o_bs), 16'd0);
        chk("t5_rst_we", 16'(o_we), 16'd0);
        chk("t5_rst_ack", 16'(o_m1_ack), 16'd0);
        cyc();
        i_reset = 1'b0; i_m1_bs = 2'b00; i_m1_we = 1'b0;
        neg();
        chk("t5_after_gnt", 16'(o_gnt), 16'd0);

        // stalled slave: timeout when enabled, indefinite hold otherwise
        i_m0_addr = 16'h0600; i_m0_bs = 2'b01; i_dat = 16'h1357;
        cyc();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(1'b0, 16'hFFFF);
            neg();
            chk("t6_gnt", 16'(o_gnt), 16'd1);
            chk("t6_timeout", 16'(o_timeout), (i == 3) ? 16'd1 : 16'd0);
            cyc();
        end
        i_m0_bs = 2'b00;
        neg();
        chk("t6_idle", 16'(o_gnt), 16'd0);
        chk("t6_timeout_end", 16'(o_timeout), 16'd0);
`else
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                i_ack = 1'b1; i_dat = 16'h5555; push(1'b0, 16'h5555);
            end
            neg();
            chk("t6_hold_gnt", 16'(o_gnt), 16'd1);
            chk("t6_timeout", 16'(o_timeout), 16'd0);
            cyc();
        end
        i_m0_bs = 2'b00; i_ack = 1'b0;
        neg();
        chk("t6_idle", 16'(o_gnt), 16'd0);
`endif
        cyc();
        cyc();
        neg();
        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
